// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the sync-decoder state encoding.
// Imported by the VGA transmit controller and by vga_sync_decoder so both
// ends of the link agree on one set of numbers.
package vga_timing_pkg;

  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_BP        = 48;
  localparam int VGA_H_ACTIVE    = 640;
  localparam int VGA_H_FP        = 16;
  localparam int VGA_H_TOTAL     = VGA_H_SYNC + VGA_H_BP + VGA_H_ACTIVE + VGA_H_FP;

  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_BP        = 33;
  localparam int VGA_V_ACTIVE    = 480;
  localparam int VGA_V_FP        = 10;
  localparam int VGA_V_TOTAL     = VGA_V_SYNC + VGA_V_BP + VGA_V_ACTIVE + VGA_V_FP;

  localparam int VGA_LOCK_FRAMES = 2;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} sync_state_e;

endpackage

// File: rtl/sync_edge_meas.sv
// Registered falling/rising edge detector with a low-width counter.
//   Clk, Reset : clock, synchronous active-high reset
//   ce         : sample enable (pixel enable)
//   tick       : width counting unit (pixels for HS, lines for VS)
//   sig        : active-low sync input
//   fall/rise  : combinational edge flags, valid on ce cycles
//   low_width  : ticks counted while low; read it on rise for the pulse width
module sync_edge_meas #(
  parameter int CW = 10
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          ce,
  input  logic          tick,
  input  logic          sig,
  output logic          fall,
  output logic          rise,
  output logic [CW-1:0] low_width
);

  logic level;

  assign fall = ce &  level & ~sig;
  assign rise = ce & ~level &  sig;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      level     <= 1'b0;
      low_width <= '0;
    end else if (ce) begin
      level <= sig;
      // The falling sample is the first low unit of the pulse.
      if (fall)
        low_width <= CW'(1);
      else if (tick && !sig)
        low_width <= low_width + 1'b1;
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: samples HS/VS/BLANK_N once per pixel,
// rebuilds the raster counters, checks the timing and reports lock.
//   Clk, Reset        : 50 MHz clock, synchronous active-high reset
//   pix_ce            : pixel enable, one Clk in two
//   VGA_HS/VS         : active-low syncs; VGA_BLANK_N high when visible
//   PixX/PixY         : recovered visible coordinate (holds outside window)
//   pix_valid         : visible pixel while locked, one Clk per pixel
//   frame_start       : VS falling edge while locked
//   locked            : timing stable
//   timing_err        : sticky, set on loss of lock
//   frame_count       : frames seen while locked, wrapping
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_FP        = VGA_H_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_FP        = VGA_V_FP,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        pix_ce,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_BLANK_N,
  output logic [9:0]  PixX,
  output logic [9:0]  PixY,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES);
  localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_FRAMES - 1);

  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic [9:0]  hs_w, vs_w;

  sync_edge_meas #(.CW(10)) u_hs (
    .Clk(Clk), .Reset(Reset), .ce(pix_ce), .tick(pix_ce), .sig(VGA_HS),
    .fall(hs_fall), .rise(hs_rise), .low_width(hs_w)
  );

  // VS width is measured in lines, so it counts HS falling edges.
  sync_edge_meas #(.CW(10)) u_vs (
    .Clk(Clk), .Reset(Reset), .ce(pix_ce), .tick(hs_fall), .sig(VGA_VS),
    .fall(vs_fall), .rise(vs_rise), .low_width(vs_w)
  );

  sync_state_e   state_q, state_n;
  logic [GW-1:0] good_q, good_n;
  logic          ferr_q, ferr_n;
  logic [9:0]    hcnt, vcnt, hcnt_n, vcnt_n;
  logic          in_win, err_now, set_err, fs;
  logic [15:0]   fc_q;

  // hcnt/vcnt hold the index of the previously sampled pixel/line, so the
  // pixel being sampled now sits at hcnt_n/vcnt_n and an edge arriving on
  // time finds the counter at its last value.
  always_comb begin
    hcnt_n = hs_fall ? 10'd0 : hcnt + 10'd1;
    vcnt_n = vs_fall ? 10'd0 : (hs_fall ? vcnt + 10'd1 : vcnt);
    in_win = (hcnt_n >= H_START) && (hcnt_n <= H_END) &&
             (vcnt_n >= V_START) && (vcnt_n <= V_END);
    err_now = pix_ce && (
        (hs_fall ? (hcnt != H_LAST) : (hcnt == H_LAST)) ||
        (vs_fall && (vcnt != V_LAST)) ||
        (hs_fall && !vs_fall && (vcnt == V_LAST)) ||
        (hs_rise && (hs_w != 10'(H_SYNC))) ||
        (vs_rise && (vs_w != 10'(V_SYNC))) ||
        (VGA_BLANK_N != in_win));
  end

  always_comb begin
    state_n = state_q;
    good_n  = good_q;
    ferr_n  = ferr_q;
    set_err = 1'b0;
    fs      = 1'b0;
    if (pix_ce) begin
      case (state_q)
        SEARCH: if (vs_fall) begin
          state_n = ACQUIRE;
          good_n  = '0;
          ferr_n  = 1'b0;
        end
        ACQUIRE: if (vs_fall) begin
          // An error on the VS edge itself belongs to the frame just ending.
          ferr_n = 1'b0;
          if (err_now || ferr_q)
            good_n = '0;
          else if (good_q == LOCK_LAST) begin
            state_n = LOCKED;
            good_n  = '0;
          end else
            good_n = good_q + 1'b1;
        end else if (err_now) begin
          good_n = '0;
          ferr_n = 1'b1;
        end
        LOCKED: if (err_now) begin
          state_n = SEARCH;
          set_err = 1'b1;
        end else if (vs_fall)
          fs = 1'b1;
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= SEARCH;
      good_q      <= '0;
      ferr_q      <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      PixX        <= '0;
      PixY        <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
      fc_q        <= '0;
    end else begin
      state_q     <= state_n;
      good_q      <= good_n;
      ferr_q      <= ferr_n;
      frame_start <= fs;
      pix_valid   <= pix_ce && (state_q == LOCKED) && in_win && VGA_BLANK_N;
      if (set_err) timing_err <= 1'b1;
      if (fs)      fc_q       <= fc_q + 16'd1;
      if (pix_ce) begin
        hcnt <= hcnt_n;
        vcnt <= vcnt_n;
        if (in_win) begin
          PixX <= hcnt_n - H_START;
          PixY <= vcnt_n - V_START;
        end
      end
    end
  end

  assign locked      = (state_q == LOCKED);
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
module tb_vga_sync_decoder;

  localparam int TH_SYNC = 4, TH_BP = 3, TH_ACT = 8, TH_FP = 2;
  localparam int TV_SYNC = 2, TV_BP = 2, TV_ACT = 4, TV_FP = 2;
  localparam int TH_TOT = TH_SYNC + TH_BP + TH_ACT + TH_FP;  // 17
  localparam int TV_TOT = TV_SYNC + TV_BP + TV_ACT + TV_FP;  // 10
  localparam int HST = TH_SYNC + TH_BP, HEN = HST + TH_ACT - 1;
  localparam int VST = TV_SYNC + TV_BP, VEN = VST + TV_ACT - 1;
  localparam int NFULL = TH_ACT * TV_ACT;

  logic        Clk, Reset, pix_ce, VGA_HS, VGA_VS, VGA_BLANK_N;
  logic [9:0]  PixX, PixY;
  logic        pix_valid, frame_start, locked, timing_err;
  logic [15:0] frame_count;

  vga_sync_decoder #(
    .H_SYNC(TH_SYNC), .H_BP(TH_BP), .H_ACTIVE(TH_ACT), .H_FP(TH_FP),
    .V_SYNC(TV_SYNC), .V_BP(TV_BP), .V_ACTIVE(TV_ACT), .V_FP(TV_FP),
    .LOCK_FRAMES(2)
  ) dut (
    .Clk(Clk), .Reset(Reset), .pix_ce(pix_ce), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .PixX(PixX), .PixY(PixY), .pix_valid(pix_valid),
    .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
    .frame_count(frame_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Per-frame scenario: mod selects the disturbance, expectations describe
  // the VS-edge pixel that opens the frame and the state at its end.
  typedef enum int {M_NONE, M_SHORT, M_VSLONG, M_KILL, M_RESET, M_FORCE} mod_e;
  typedef struct {
    mod_e mod; int mx; int my;
    bit lk0; bit fs0; bit lk_end; bit te_end; int fc_end; int nvalid;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(mod_e m, int mx, int my, bit lk0, bit fs0,
                              bit lke, bit tee, int fce, int nv);
    vec_t v;
    v.mod = m; v.mx = mx; v.my = my; v.lk0 = lk0; v.fs0 = fs0;
    v.lk_end = lke; v.te_end = tee; v.fc_end = fce; v.nvalid = nv;
    return v;
  endfunction

  // Samples right after the pix_ce edge (s_*) and after the following Clk (o_*).
  logic        s_pv, s_fs, s_lk, s_te, o_pv, o_fs;
  logic [9:0]  s_x, s_y;
  logic [15:0] s_fc;

  task automatic step(input logic hs, input logic vs, input logic bl, input logic rst);
    @(negedge Clk);
    pix_ce = 1'b1; VGA_HS = hs; VGA_VS = vs; VGA_BLANK_N = bl; Reset = rst;
    @(posedge Clk); #1;
    s_pv = pix_valid; s_fs = frame_start; s_lk = locked; s_te = timing_err;
    s_x = PixX; s_y = PixY; s_fc = frame_count;
    @(negedge Clk);
    pix_ce = 1'b0; Reset = 1'b0;
    @(posedge Clk); #1;
    o_pv = pix_valid; o_fs = frame_start;
  endtask

  task automatic run_frame(input int k);
    vec_t v;
    int nvalid, bad, offce, fx, fy, lx, ly, vs_low, line_len, ex, ey;
    bit lk0, fs0, fs1;
    string p;
    v = vt[k];
    p = $sformatf("frame%0d", k);
    nvalid = 0; bad = 0; offce = 0; fx = -1; fy = -1; lx = -1; ly = -1;
    lk0 = 0; fs0 = 0; fs1 = 0;
    vs_low = (v.mod == M_VSLONG) ? TV_SYNC + 1 : TV_SYNC;
    ex = v.mx; ey = v.my;
    if (v.mod == M_SHORT)  begin ex = 0; ey = v.my + 1; end
    if (v.mod == M_VSLONG) begin ex = 0; ey = TV_SYNC + 1; end
    for (int y = 0; y < TV_TOT; y++) begin
      line_len = (v.mod == M_SHORT && y == v.my) ? TH_TOT - 1 : TH_TOT;
      for (int x = 0; x < line_len; x++) begin
        logic hs, vs, bl, rst;
        bit lk_pre, at_err;
        hs = (x >= TH_SYNC);
        vs = (y >= vs_low);
        bl = (x >= HST && x <= HEN && y >= VST && y <= VEN) &&
             !(v.mod == M_KILL && x == v.mx && y == v.my);
        rst = (v.mod == M_RESET && x == v.mx && y == v.my);
        lk_pre = locked;
        step(hs, vs, bl, rst);
        if (x == 0 && y == 0) begin lk0 = s_lk; fs0 = s_fs; fs1 = o_fs; end
        if (s_pv) begin
          nvalid++;
          if (fx < 0) begin fx = int'(s_x); fy = int'(s_y); end
          lx = int'(s_x); ly = int'(s_y);
          if (int'(s_x) != x - HST || int'(s_y) != y - VST) bad++;
        end
        if (o_pv) offce++;
        at_err = (v.mod inside {M_SHORT, M_VSLONG, M_KILL, M_RESET}) && x == ex && y == ey;
        if (at_err) begin
          chk({p, "_lock_before_fault"}, int'(lk_pre), 1);
          chk({p, "_lock_after_fault"}, int'(s_lk), 0);
          if (v.mod == M_RESET) begin
            chk({p, "_reset_flags"}, int'({s_pv, s_fs, s_te}), 0);
            chk({p, "_reset_pixx"}, int'(s_x), 0);
            chk({p, "_reset_pixy"}, int'(s_y), 0);
            chk({p, "_reset_fcount"}, int'(s_fc), 0);
          end else begin
            chk({p, "_timing_err_at_fault"}, int'(s_te), 1);
          end
          if (v.mod == M_KILL) chk({p, "_pix_valid_blanked"}, int'(s_pv), 0);
        end
        if (v.mod == M_FORCE && x == v.mx && y == v.my) begin
          force dut.fc_q = 16'hFFFF;
          @(negedge Clk);
          release dut.fc_q;
        end
      end
    end
    chk({p, "_locked_at_vs"}, int'(lk0), int'(v.lk0));
    chk({p, "_frame_start_at_vs"}, int'(fs0), int'(v.fs0));
    chk({p, "_frame_start_one_clk"}, int'(fs1), 0);
    chk({p, "_locked_end"}, int'(s_lk), int'(v.lk_end));
    chk({p, "_timing_err_end"}, int'(s_te), int'(v.te_end));
    chk({p, "_frame_count_end"}, int'(s_fc), v.fc_end);
    chk({p, "_valid_count"}, nvalid, v.nvalid);
    chk({p, "_coord_errors"}, bad, 0);
    chk({p, "_valid_off_ce"}, offce, 0);
    if (v.nvalid == NFULL) begin
      chk({p, "_first_xy"}, fx * 1024 + fy, 0);
      chk({p, "_last_xy"}, lx * 1024 + ly, (TH_ACT - 1) * 1024 + (TV_ACT - 1));
    end
  endtask

  initial begin
    Reset = 1'b1; pix_ce = 1'b0; VGA_HS = 1'b1; VGA_VS = 1'b1; VGA_BLANK_N = 1'b0;

    //            mod       mx  my lk0 fs0 lkE teE fcE    nvalid
    vt.push_back(mk(M_NONE,   0, 0, 0, 0, 0, 0, 0,     0));     // VS1 -> ACQUIRE
    vt.push_back(mk(M_NONE,   0, 0, 0, 0, 0, 0, 0,     0));     // VS2 good=1
    vt.push_back(mk(M_NONE,   0, 0, 1, 0, 1, 0, 0,     NFULL)); // VS3 locks, no pulse
    vt.push_back(mk(M_NONE,   0, 0, 1, 1, 1, 0, 1,     NFULL)); // first frame_start
    vt.push_back(mk(M_SHORT,  0, 5, 1, 1, 0, 1, 2,     16));    // 16-pixel line
    vt.push_back(mk(M_NONE,   0, 0, 0, 0, 0, 1, 2,     0));
    vt.push_back(mk(M_NONE,   0, 0, 0, 0, 0, 1, 2,     0));
    vt.push_back(mk(M_NONE,   0, 0, 1, 0, 1, 1, 2,     NFULL)); // relocked
    vt.push_back(mk(M_VSLONG, 0, 0, 1, 1, 0, 1, 3,     0));     // VS low 3 lines
    vt.push_back(mk(M_NONE,   0, 0, 0, 0, 0, 1, 3,     0));
    vt.push_back(mk(M_NONE,   0, 0, 0, 0, 0, 1, 3,     0));
    vt.push_back(mk(M_NONE,   0, 0, 1, 0, 1, 1, 3,     NFULL));
    vt.push_back(mk(M_KILL,  11, 6, 1, 1, 0, 1, 4,     20));    // BLANK_N low at (4,2)
    vt.push_back(mk(M_NONE,   0, 0, 0, 0, 0, 1, 4,     0));
    vt.push_back(mk(M_NONE,   0, 0, 0, 0, 0, 1, 4,     0));
    vt.push_back(mk(M_NONE,   0, 0, 1, 0, 1, 1, 4,     NFULL));
    vt.push_back(mk(M_RESET, 10, 5, 1, 1, 0, 0, 0,     11));    // mid-line reset
    vt.push_back(mk(M_NONE,   0, 0, 0, 0, 0, 0, 0,     0));
    vt.push_back(mk(M_NONE,   0, 0, 0, 0, 0, 0, 0,     0));
    vt.push_back(mk(M_FORCE,  0, 5, 1, 0, 1, 0, 65535, NFULL)); // preload count
    vt.push_back(mk(M_NONE,   0, 0, 1, 1, 1, 0, 0,     NFULL)); // wrap to 0

    repeat (4) @(posedge Clk);
    #1;
    chk("reset_flags", int'({pix_valid, frame_start, locked, timing_err}), 0);
    chk("reset_pixx", int'(PixX), 0);
    chk("reset_pixy", int'(PixY), 0);
    chk("reset_fcount", int'(frame_count), 0);
    @(negedge Clk);
    Reset = 1'b0;

    // Enter on the last line just after HS so the next frame start is a
    // clean VS falling edge.
    for (int x = TH_SYNC; x < TH_TOT; x++) step(1'b1, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < vt.size(); k++) run_frame(k);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
